// File: rtl/hash_pe_dispatch_crossbar.sv
// hash_pe_dispatch_crossbar
// Scatters one issue row of hash requests onto the hash PE lanes selected by
// the low hash bits. Slots that collide on a PE are serialized over several
// beats in ascending slot order. Each beat is a masked per-PE vector.
module hash_pe_dispatch_crossbar #(
    parameter int NUM_HASH_PE           = 16,
    parameter int NUM_HASH_PE_LOG2      = 4,
    parameter int HASH_ISSUE_WIDTH      = 8,
    parameter int HASH_ISSUE_WIDTH_LOG2 = 3,
    parameter int ADDR_WIDTH            = 32,
    parameter int HASH_BITS             = 15
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  input_valid,
    input  logic [ADDR_WIDTH-1:0]                 input_head_addr,
    input  logic [HASH_ISSUE_WIDTH-1:0]           input_slot_valid,
    input  logic [HASH_ISSUE_WIDTH*HASH_BITS-1:0] input_hash,
    input  logic                                  input_delim,
    input  logic [HASH_ISSUE_WIDTH*8-1:0]         input_data,
    output logic                                  input_ready,
    output logic                                  output_valid,
    output logic [NUM_HASH_PE-1:0]                output_mask,
    output logic [NUM_HASH_PE*ADDR_WIDTH-1:0]     output_addr,
    output logic [NUM_HASH_PE*HASH_BITS-1:0]      output_hash,
    output logic [NUM_HASH_PE-1:0]                output_delim,
    output logic [HASH_ISSUE_WIDTH*8-1:0]         output_data,
    input  logic                                  output_ready
);

    // Row buffer
    logic                                  buf_valid;
    logic [ADDR_WIDTH-1:0]                 head_q;
    logic [HASH_ISSUE_WIDTH-1:0]           pending_q;
    logic [HASH_ISSUE_WIDTH*HASH_BITS-1:0] hash_q;
    logic                                  delim_q;
    logic [HASH_ISSUE_WIDTH*8-1:0]         data_q;

    // Arbitration results
    logic [NUM_HASH_PE-1:0]           grant_pe;
    logic [HASH_ISSUE_WIDTH_LOG2-1:0] grant_slot [NUM_HASH_PE];
    logic [HASH_ISSUE_WIDTH-1:0]      grant_set;

    logic load;
    logic last_beat;
    logic last_issue;
    logic accept;
    logic row_empty;

    logic [NUM_HASH_PE*ADDR_WIDTH-1:0] next_addr;
    logic [NUM_HASH_PE*HASH_BITS-1:0]  next_hash;
    logic [NUM_HASH_PE-1:0]            next_delim;

    // Per PE, grant the lowest-index pending slot whose low hash bits select it;
    // scanning downward lets the lowest matching slot overwrite the others.
    always_comb begin
        grant_pe  = '0;
        grant_set = '0;
        for (int p = 0; p < NUM_HASH_PE; p++) begin
            grant_slot[p] = '0;
        end
        for (int p = 0; p < NUM_HASH_PE; p++) begin
            for (int j = HASH_ISSUE_WIDTH - 1; j >= 0; j--) begin
                if (pending_q[j] &&
                    hash_q[j*HASH_BITS +: NUM_HASH_PE_LOG2] == NUM_HASH_PE_LOG2'(p)) begin
                    grant_pe[p]   = 1'b1;
                    grant_slot[p] = HASH_ISSUE_WIDTH_LOG2'(j);
                end
            end
            if (grant_pe[p]) begin
                grant_set[grant_slot[p]] = 1'b1;
            end
        end
    end

    // Handshake: the output register loads when it is empty or being drained,
    // and a new row may enter when the buffer is free or its last beat is leaving.
    always_comb begin
        load        = buf_valid && (!output_valid || output_ready);
        last_beat   = (grant_set == pending_q);
        last_issue  = load && last_beat;
        input_ready = !buf_valid || last_issue;
        accept      = input_valid && input_ready;
        row_empty   = (input_slot_valid == '0);
    end

    // Build the lane payload for the beat that would load this cycle.
    always_comb begin
        next_addr  = '0;
        next_hash  = '0;
        next_delim = {NUM_HASH_PE{delim_q && last_beat}} & grant_pe;
        for (int p = 0; p < NUM_HASH_PE; p++) begin
            if (grant_pe[p]) begin
                next_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = head_q | ADDR_WIDTH'(grant_slot[p]);
                next_hash[p*HASH_BITS +: HASH_BITS]   = hash_q[grant_slot[p]*HASH_BITS +: HASH_BITS];
            end
        end
    end

    // Row buffer: capture an accepted row, otherwise retire granted slots on load.
    // An empty row never occupies the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            pending_q <= '0;
            head_q    <= '0;
            hash_q    <= '0;
            delim_q   <= 1'b0;
            data_q    <= '0;
        end else if (accept) begin
            buf_valid <= !row_empty;
            pending_q <= input_slot_valid;
            head_q    <= input_head_addr;
            hash_q    <= input_hash;
            delim_q   <= input_delim;
            data_q    <= input_data;
        end else if (load) begin
            pending_q <= pending_q & ~grant_set;
            if ((pending_q & ~grant_set) == '0) begin
                buf_valid <= 1'b0;
            end
        end
    end

    // Flag an empty row that claims to end a block; it carries nothing to delimit.
    always_ff @(posedge clk) begin
        if (!rst && accept && row_empty && input_delim) begin
            $error("hash_pe_dispatch_crossbar: empty row accepted with input_delim=1");
        end
    end

    // Output register: load a new beat, drop valid once consumed, hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            output_valid <= 1'b0;
            output_mask  <= '0;
            output_addr  <= '0;
            output_hash  <= '0;
            output_delim <= '0;
            output_data  <= '0;
        end else if (load) begin
            output_valid <= 1'b1;
            output_mask  <= grant_pe;
            output_addr  <= next_addr;
            output_hash  <= next_hash;
            output_delim <= next_delim;
            output_data  <= data_q;
        end else if (output_ready) begin
            output_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hash_pe_dispatch_crossbar.sv
// Testbench for hash_pe_dispatch_crossbar: a row model fills a scoreboard of
// expected beats; a negedge monitor pops and compares every consumed beat.
module tb_hash_pe_dispatch_crossbar;

    logic         clk;
    logic         rst;
    logic         input_valid;
    logic [31:0]  input_head_addr;
    logic [7:0]   input_slot_valid;
    logic [119:0] input_hash;
    logic         input_delim;
    logic [63:0]  input_data;
    logic         input_ready;
    logic         output_valid;
    logic [15:0]  output_mask;
    logic [511:0] output_addr;
    logic [239:0] output_hash;
    logic [15:0]  output_delim;
    logic [63:0]  output_data;
    logic         output_ready;

    typedef struct {
        logic [15:0]  mask;
        logic [511:0] addr;
        logic [239:0] hash;
        logic [15:0]  delim;
        logic [63:0]  data;
    } beat_t;

    beat_t sb[$];
    int    beat_cycles[$];
    int    checks = 0;
    int    errors = 0;
    int    beats_seen = 0;
    int    cyc = 0;

    hash_pe_dispatch_crossbar dut (
        .clk              (clk),
        .rst              (rst),
        .input_valid      (input_valid),
        .input_head_addr  (input_head_addr),
        .input_slot_valid (input_slot_valid),
        .input_hash       (input_hash),
        .input_delim      (input_delim),
        .input_data       (input_data),
        .input_ready      (input_ready),
        .output_valid     (output_valid),
        .output_mask      (output_mask),
        .output_addr      (output_addr),
        .output_hash      (output_hash),
        .output_delim     (output_delim),
        .output_data      (output_data),
        .output_ready     (output_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure beat spacing
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every beat the DUT hands over is compared with the model
    always @(negedge clk) begin
        if (output_valid && output_ready) begin
            beats_seen++;
            beat_cycles.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_beat: got mask %h, required no beat", output_mask);
            end else begin
                beat_t e;
                e = sb.pop_front();
                checks += 4;
                if (output_mask !== e.mask) begin
                    errors++;
                    $display("[TB] FAIL beat_mask: got %h, required %h", output_mask, e.mask);
                end
                if (output_delim !== e.delim) begin
                    errors++;
                    $display("[TB] FAIL beat_delim: got %h, required %h", output_delim, e.delim);
                end
                if (output_addr !== e.addr) begin
                    errors++;
                    $display("[TB] FAIL beat_addr: got %h, required %h", output_addr, e.addr);
                end
                if (output_hash !== e.hash) begin
                    errors++;
                    $display("[TB] FAIL beat_hash: got %h, required %h", output_hash, e.hash);
                end
                if (output_data !== e.data) begin
                    errors++;
                    $display("[TB] FAIL beat_data: got %h, required %h", output_data, e.data);
                end
            end
        end
    end

    // Reference model: a slot's beat index is the number of earlier valid slots
    // sharing its PE; delimiters only go on the final beat of the row.
    function automatic void model_row(input logic [31:0] head, input logic [7:0] sv,
                                      input logic [119:0] hv, input logic dl,
                                      input logic [63:0] dt);
        beat_t tmp [8];
        int    rank [8];
        int    nbeats;
        nbeats = 0;
        for (int b = 0; b < 8; b++) begin
            tmp[b].mask  = '0;
            tmp[b].addr  = '0;
            tmp[b].hash  = '0;
            tmp[b].delim = '0;
            tmp[b].data  = dt;
        end
        for (int j = 0; j < 8; j++) begin
            rank[j] = 0;
            if (sv[j]) begin
                for (int k = 0; k < j; k++) begin
                    if (sv[k] && hv[k*15 +: 4] == hv[j*15 +: 4]) rank[j]++;
                end
                if (rank[j] + 1 > nbeats) nbeats = rank[j] + 1;
            end
        end
        for (int j = 0; j < 8; j++) begin
            if (sv[j]) begin
                int pe;
                pe = int'(hv[j*15 +: 4]);
                tmp[rank[j]].mask[pe]          = 1'b1;
                tmp[rank[j]].addr[pe*32 +: 32] = head | 32'(j);
                tmp[rank[j]].hash[pe*15 +: 15] = hv[j*15 +: 15];
            end
        end
        if (nbeats > 0 && dl) tmp[nbeats-1].delim = tmp[nbeats-1].mask;
        for (int b = 0; b < nbeats; b++) sb.push_back(tmp[b]);
    endfunction

    // Present one row (called just after a rising edge) and hold it until accepted
    task automatic send_row(input logic [31:0] head, input logic [7:0] sv,
                            input logic [119:0] hv, input logic dl, input logic [63:0] dt);
        int c;
        input_head_addr  = head;
        input_slot_valid = sv;
        input_hash       = hv;
        input_delim      = dl;
        input_data       = dt;
        input_valid      = 1'b1;
        c = 0;
        @(negedge clk);
        while (!input_ready && c < 100) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (!input_ready) begin
            errors++;
            $display("[TB] FAIL row_accept: input_ready got 0 for 100 cycles, required 1");
        end else begin
            model_row(head, sv, hv, dl, dt);
        end
        @(posedge clk);
        #1;
        input_valid = 1'b0;
    endtask

    function automatic logic [119:0] collide_hashes(input logic [3:0] pe);
        logic [119:0] hv;
        for (int j = 0; j < 8; j++) hv[j*15 +: 15] = {11'($urandom), pe};
        return hv;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (output_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b, required 0", output_valid);
        end
        if (output_mask !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_mask: got %h, required 0000", output_mask);
        end
        if (output_delim !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_delim: got %h, required 0000", output_delim);
        end
        if (input_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b, required 1", input_ready);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_conflict_free;
        logic [119:0] hv;
        int c;
        for (int j = 0; j < 8; j++) hv[j*15 +: 15] = 15'(j);
        send_row(32'h100, 8'hFF, hv, 1'b1, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        checks++;
        if (output_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL latency_early: output_valid got %b at t+1, required 0", output_valid);
        end
        @(negedge clk);
        checks += 4;
        if (output_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL latency_t2: output_valid got %b at t+2, required 1", output_valid);
        end
        if (output_mask !== 16'h00FF) begin
            errors++;
            $display("[TB] FAIL cf_mask: got %h, required 00ff", output_mask);
        end
        if (output_addr[3*32 +: 32] !== 32'h103) begin
            errors++;
            $display("[TB] FAIL cf_lane3_addr: got %h, required 00000103", output_addr[3*32 +: 32]);
        end
        if (output_delim !== 16'h00FF) begin
            errors++;
            $display("[TB] FAIL cf_delim: got %h, required 00ff", output_delim);
        end
        @(posedge clk);
        #1;
        c = 0;
        while (sb.size() != 0 && c < 200) begin @(posedge clk); #1; c++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_conflict_free: %0d beats outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_full_collision;
        int c;
        int low_cnt;
        send_row(32'h200, 8'hFF, collide_hashes(4'd5), 1'b1, 64'hDEAD_BEEF_0BAD_F00D);
        low_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (input_ready) break;
            low_cnt++;
        end
        checks++;
        if (low_cnt != 7) begin
            errors++;
            $display("[TB] FAIL collision_ready_low: low for %0d cycles, required 7", low_cnt);
        end
        @(posedge clk);
        #1;
        c = 0;
        while (sb.size() != 0 && c < 200) begin @(posedge clk); #1; c++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_full_collision: %0d beats outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_partial_collision;
        logic [119:0] hv;
        int base;
        int c;
        hv = '0;
        hv[0*15 +: 15] = 15'h0011;
        hv[2*15 +: 15] = 15'h0221;
        hv[6*15 +: 15] = 15'h7FF1;
        hv[1*15 +: 15] = 15'h0019;
        hv[3*15 +: 15] = 15'h1239;
        base = beats_seen;
        send_row(32'h340, 8'b0100_1111, hv, 1'b1, 64'h1122_3344_5566_7788);
        c = 0;
        while (sb.size() != 0 && c < 200) begin @(posedge clk); #1; c++; end
        repeat (3) @(posedge clk);
        #1;
        checks += 2;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_partial: %0d beats outstanding, required 0", sb.size());
        end
        if (beats_seen - base != 3) begin
            errors++;
            $display("[TB] FAIL partial_beat_count: got %0d, required 3", beats_seen - base);
        end
    endtask

    task automatic test_backpressure;
        logic [15:0]  s_mask;
        logic [511:0] s_addr;
        logic [239:0] s_hash;
        logic [15:0]  s_delim;
        logic [63:0]  s_data;
        int base;
        int c;
        base = beats_seen;
        send_row(32'h200, 8'hFF, collide_hashes(4'd5), 1'b1, 64'hA5A5_5A5A_0F0F_F0F0);
        c = 0;
        while (beats_seen - base < 3 && c < 50) begin @(posedge clk); #1; c++; end
        output_ready = 1'b0;
        s_mask  = output_mask;
        s_addr  = output_addr;
        s_hash  = output_hash;
        s_delim = output_delim;
        s_data  = output_data;
        checks++;
        if (output_valid !== 1'b1 || s_addr[5*32 +: 32] !== 32'h203) begin
            errors++;
            $display("[TB] FAIL bp_beat4: valid %b lane5 addr %h, required 1 and 00000203",
                     output_valid, s_addr[5*32 +: 32]);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks += 2;
            if (output_valid !== 1'b1 || output_mask !== s_mask || output_addr !== s_addr ||
                output_hash !== s_hash || output_delim !== s_delim || output_data !== s_data) begin
                errors++;
                $display("[TB] FAIL bp_hold: cycle %0d valid %b mask %h lane5 %h, required held mask %h lane5 %h",
                         k, output_valid, output_mask, output_addr[5*32 +: 32], s_mask, s_addr[5*32 +: 32]);
            end
            if (input_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_input_ready: got %b, required 0", input_ready);
            end
            @(posedge clk);
        end
        #1;
        output_ready = 1'b1;
        c = 0;
        while (sb.size() != 0 && c < 200) begin @(posedge clk); #1; c++; end
        repeat (3) @(posedge clk);
        #1;
        checks += 2;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_backpressure: %0d beats outstanding, required 0", sb.size());
        end
        if (beats_seen - base != 8) begin
            errors++;
            $display("[TB] FAIL bp_beat_count: got %0d, required 8", beats_seen - base);
        end
    endtask

    task automatic test_back_to_back;
        logic [119:0] hv;
        int c;
        int ones;
        int twos;
        beat_cycles.delete();
        for (int r = 0; r < 11; r++) begin
            if (r == 5) begin
                send_row(32'h0, 8'h00, '0, 1'b0, 64'h0);
            end else begin
                for (int j = 0; j < 8; j++) hv[j*15 +: 15] = {11'($urandom), 4'(j + 3*r)};
                send_row(32'h1000 + 32'(r*8), 8'($urandom_range(1, 255)), hv,
                         1'($urandom), {$urandom, $urandom});
            end
        end
        c = 0;
        while (sb.size() != 0 && c < 200) begin @(posedge clk); #1; c++; end
        repeat (3) @(posedge clk);
        #1;
        ones = 0;
        twos = 0;
        for (int i = 1; i < beat_cycles.size(); i++) begin
            if (beat_cycles[i] - beat_cycles[i-1] == 1) ones++;
            else if (beat_cycles[i] - beat_cycles[i-1] == 2) twos++;
        end
        checks += 3;
        if (beat_cycles.size() != 10 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL stream_beats: got %0d beats, %0d outstanding, required 10 and 0",
                     beat_cycles.size(), sb.size());
        end
        if (ones != 8) begin
            errors++;
            $display("[TB] FAIL stream_consecutive: got %0d single-cycle gaps, required 8", ones);
        end
        if (twos != 1) begin
            errors++;
            $display("[TB] FAIL stream_bubble: got %0d bubbles, required 1", twos);
        end
    endtask

    task automatic test_reset_mid_row;
        logic [119:0] hv;
        int base;
        int c;
        base = beats_seen;
        send_row(32'h200, 8'hFF, collide_hashes(4'd5), 1'b1, 64'h5555_AAAA_3333_CCCC);
        c = 0;
        while (beats_seen - base < 2 && c < 50) begin @(posedge clk); #1; c++; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        checks += 2;
        if (output_valid !== 1'b0 || output_mask !== 16'h0) begin
            errors++;
            $display("[TB] FAIL midrow_reset_out: valid %b mask %h, required 0 and 0000",
                     output_valid, output_mask);
        end
        if (input_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrow_reset_ready: got %b, required 1", input_ready);
        end
        rst = 1'b0;
        for (int j = 0; j < 8; j++) hv[j*15 +: 15] = 15'(j);
        base = beats_seen;
        send_row(32'h100, 8'hFF, hv, 1'b1, 64'h0123_4567_89AB_CDEF);
        c = 0;
        while (sb.size() != 0 && c < 200) begin @(posedge clk); #1; c++; end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (beats_seen - base != 1 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL midrow_after_reset: got %0d beats, %0d outstanding, required 1 and 0",
                     beats_seen - base, sb.size());
        end
    endtask

    initial begin
        rst              = 1'b1;
        input_valid      = 1'b0;
        input_head_addr  = '0;
        input_slot_valid = '0;
        input_hash       = '0;
        input_delim      = 1'b0;
        input_data       = '0;
        output_ready     = 1'b1;
        test_reset();
        test_conflict_free();
        test_full_collision();
        test_partial_collision();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_row();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hash_pe_dispatch_crossbar.md
Name: hash_pe_dispatch_crossbar

Overview:
Scatter-side companion of the post-hash PE reorder crossbar. It accepts one issue row of up to HASH_ISSUE_WIDTH hash requests, each slot already carrying its hash value. It routes every valid slot to the hash PE selected by the low hash bits, serializing slots that collide on the same PE. Each output beat is one masked NUM_HASH_PE-wide vector, which is exactly the per-PE mask/addr/delim/data transaction that the post-hash reorder stage consumes.

Parameters:
NUM_HASH_PE, 16, number of hash PEs; power of two.
NUM_HASH_PE_LOG2, 4, log2(NUM_HASH_PE); selects the PE from hash[NUM_HASH_PE_LOG2-1:0].
HASH_ISSUE_WIDTH, 8, slots per row; power of two.
HASH_ISSUE_WIDTH_LOG2, 3, log2(HASH_ISSUE_WIDTH).
ADDR_WIDTH, 32, byte address width.
HASH_BITS, 15, hash value width per slot.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
input_valid  in  1  row valid
input_head_addr  in  ADDR_WIDTH  row base address; low HASH_ISSUE_WIDTH_LOG2 bits are zero
input_slot_valid  in  HASH_ISSUE_WIDTH  per-slot request valid
input_hash  in  HASH_ISSUE_WIDTH*HASH_BITS  per-slot hash; slot j at [j*HASH_BITS +: HASH_BITS]
input_delim  in  1  last row of block
input_data  in  HASH_ISSUE_WIDTH*8  row bytes
input_ready  out  1  row accepted when valid&ready
output_valid  out  1  beat valid
output_mask  out  NUM_HASH_PE  PE lanes carrying a request this beat
output_addr  out  NUM_HASH_PE*ADDR_WIDTH  per-lane byte address = head_addr | slot index
output_hash  out  NUM_HASH_PE*HASH_BITS  per-lane hash
output_delim  out  NUM_HASH_PE  per-lane delimiter
output_data  out  HASH_ISSUE_WIDTH*8  row bytes, repeated on every beat of the row
output_ready  in  1  beat consumed when valid&ready

Behaviour:
- Pipeline has two registers: the row buffer (head_addr, pending[HASH_ISSUE_WIDTH], hashes, delim, data, buf_valid) and the output register.
- Reset: buf_valid=0, pending=0, output_valid=0, output_mask=0, output_delim=0. Other output payload is don't-care but held at 0. Reset mid-row discards all pending slots and any held beat.
- Row accept:
  - input_ready = ~buf_valid | last_issue, where last_issue means the grant set equals pending and the output register can load this cycle.
  - On accept, pending <= input_slot_valid.
  - A row accepted with input_slot_valid=0 and input_delim=0 is dropped. buf_valid stays 0, and the next row may be accepted the following cycle.
  - An all-zero row with input_delim=1 is illegal: simulation $error, no output.
- Arbitration is combinational from the row buffer.
  - For each PE p, grant the lowest-index pending slot j whose hash[NUM_HASH_PE_LOG2-1:0]==p.
  - Each slot targets one PE, so at most one grant per PE per beat and at most one beat per slot.
- Output register:
  - Loads when buf_valid & (~output_valid | output_ready).
  - output_mask[p] = PE p granted.
  - Lane p: addr = head_addr | j, hash = slot j hash.
  - output_delim[p] = buffered delim & mask[p] & (this beat clears pending).
  - Ungranted lanes carry addr/hash/delim of 0.
  - On load, the granted slots are cleared from pending. When pending becomes 0, buf_valid clears unless a new row is accepted in the same cycle.
- Beats per row = max over PEs of slots mapped to that PE, in the range 1..HASH_ISSUE_WIDTH.
- A colliding PE receives slots in ascending slot order, one per beat.
- A beat never mixes rows.
- Latency: row accepted at cycle t gives its first beat at output_valid in cycle t+2.
- Throughput: conflict-free rows stream at one beat per cycle back-to-back.
- Backpressure: while output_valid & ~output_ready, the whole output payload is held stable, pending is frozen, and input_ready = ~buf_valid.
- Simultaneous events: the last beat of row N loading and row N+1 being accepted in the same cycle is legal and required for full throughput.

Test Plan:
1. Conflict-free row. head 0x100, all slots valid, slot j hash=j, delim=1 → single beat two cycles later: mask=0x00FF, lane3 addr=0x103, delim=0x00FF, output_data equals input_data.
2. Full collision. All 8 slots have hash low bits=5, head 0x200 → 8 consecutive beats, each mask=0x0020, lane5 addr 0x200..0x207 in order. Delim set only on the 8th beat if input_delim=1. input_ready stays low until the 8th beat loads.
3. Partial collision. Slots 0,2,6 → PE1 and slots 1,3 → PE9; others invalid → beat 1 mask=0x0202 (slots 0,1), beat 2 mask=0x0202 (slots 2,3), beat 3 mask=0x0002 (slot 6).
4. Backpressure. Scenario 2 with output_ready low for 3 cycles at beat 4 → beat 4 payload held identical. No beat skipped or duplicated; 8 beats total.
5. Stream and drop. 10 back-to-back conflict-free rows interleaved with one empty delim=0 row, output_ready=1 → 10 beats on consecutive cycles except a single bubble for the dropped row.
6. Reset mid-row. Assert rst during beat 3 of scenario 2 → output_valid=0 the next cycle. After release, a new row from scenario 1 produces exactly its one beat.
